pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the successor to the fixed per-field dff latches between pipeline stages (e.g. EX/MEM).
- Carries a data bundle and a control bundle with a valid/ready handshake.
- Contains a two-entry skid buffer so backpressure never loses an instruction.
- A flush turns in-flight contents into bubbles whose control bits are all zero.
- Includes a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// The main entry drives the outputs directly. The skid entry holds the instruction
// accepted while the downstream stalls, so backpressure never drops one.
// Control bits of an invalid entry are always zero, so a bubble carries no side effects.
// Data bits are never cleared. Only reset changes them without a load.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic acc;
    logic pop;

    // in_ready depends only on registered state, which breaks the ready path to upstream.
    assign in_ready  = ~skid_vld_q;
    assign acc       = in_valid & in_ready;
    assign pop       = main_vld_q & out_ready;

    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state of the two entries. A flush overrides every transfer.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Squash: control goes to zero, data is left as is.
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
        end else if (!main_vld_q) begin
            // Empty
            if (acc) begin
                main_vld_d  = 1'b1;
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end else if (!skid_vld_q) begin
            // One entry held
            if (pop && acc) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end else if (pop) begin
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end else if (acc) begin
                skid_vld_d  = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end
        end else if (pop) begin
            // Two entries held. The skid entry moves up behind the popped one.
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
        end
    end

    // Saturating count of cycles where the output is held off by the downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (main_vld_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. The driver pushes every accepted instruction into an expected
// queue. A negedge monitor models the register as a bounded FIFO of depth two and compares
// the outputs against it on every cycle.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W  = 48;
    localparam int unsigned CTRL_W  = 10;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } item_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              stat_clr = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .stat_clr (stat_clr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrs   = 0;

    // Reference model: expected FIFO plus occupancy, last shown data and stall count.
    item_t             exp_q[$];
    int                occ = 0;
    logic              acc_pend = 1'b0;
    logic [DATA_W-1:0] last_data = '0;
    int unsigned       cnt_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable here, between the driver update and the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 64'(out_valid), 64'(occ > 0));
            if (occ > 0 && exp_q.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q[0].d));
                chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
                last_data = exp_q[0].d;
            end else begin
                chk("model_sync", 64'(occ), 64'(0));
                chk("hold_data", 64'(out_data), 64'(last_data));
                chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
            end
            chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
            if (stat_clr) cnt_m = 0;
            else if (occ > 0 && !out_ready && cnt_m != CNT_MAX) cnt_m++;
            if (occ > 0 && out_ready) begin
                void'(exp_q.pop_front());
                occ--;
            end
            if (acc_pend) occ++;
            if (flush) begin
                exp_q.delete();
                occ = 0;
            end
            acc_pend = 1'b0;
        end
    end

    // One clock cycle of stimulus. Inputs change 1 time unit after the rising edge.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic fl, input logic ordy, input logic clr,
                         output logic accepted);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        stat_clr  = clr;
        chk("in_ready", 64'(in_ready), 64'(occ < 2));
        accepted = iv && (occ < 2);
        acc_pend = accepted && !fl;
        if (acc_pend) exp_q.push_back('{d: d, c: c});
    endtask

    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic fl, input logic ordy, input logic clr);
        logic a;
        cycle(iv, d, c, fl, ordy, clr, a);
    endtask

    // Asserts reset between edges and checks that the outputs clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        exp_q.delete();
        occ       = 0;
        acc_pend  = 1'b0;
        last_data = '0;
        cnt_m     = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic              a;
        logic [63:0]       r;
        logic [DATA_W-1:0] rd;
        logic [CTRL_W-1:0] rc;

        // 1. Reset with one entry in flight.
        do_reset();
        step(1'b1, 48'h0000_0000_00AB, 10'h3FF, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ctrl", 64'(out_ctrl), 64'h3FF);
        do_reset();

        // 2. Streaming at full rate.
        for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), CTRL_W'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // 3. Backpressure: A and B fill both entries. C waits upstream until in_ready returns.
        step(1'b1, 48'hA, 10'h0A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 48'hB, 10'h0B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 48'hC, 10'h0C, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_data", 64'(out_data), 64'hA);
        a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) cycle(1'b1, 48'hC, 10'h0C, 1'b0, 1'b1, 1'b0, a);
        chk("bp_c_accepted", 64'(a), 64'(1));
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // 4. Flush with both entries held and no input.
        step(1'b1, 48'hD1, 10'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 48'hD2, 10'h12, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("fl2_out_valid", 64'(out_valid), 64'(0));
        chk("fl2_in_ready", 64'(in_ready), 64'(1));
        chk("fl2_out_data", 64'(out_data), 64'hD1);

        // 5. Flush with one entry held and an input offered in the same cycle.
        step(1'b1, 48'hE1, 10'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 48'hE2, 10'h22, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("fl1_out_valid", 64'(out_valid), 64'(0));
        chk("fl1_out_data", 64'(out_data), 64'hE1);

        // 6. Drain to a bubble.
        step(1'b1, 48'hF00D, 10'h2A, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("drain_out_data", 64'(out_data), 64'hF00D);
        chk("drain_out_ctrl", 64'(out_ctrl), 64'(0));

        // 7. Counter saturation, then clear while still stalled.
        step(1'b1, 48'h5A5A, 10'h155, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat_15", 64'(stall_cnt), 64'(15));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat_held", 64'(stall_cnt), 64'(15));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("clr_zero", 64'(stall_cnt), 64'(0));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("clr_then_one", 64'(stall_cnt), 64'(1));

        // Random traffic with occasional flush, clear and reset.
        for (int i = 0; i < 3000; i++) begin
            if (i % 997 == 500) do_reset();
            r  = {$urandom, $urandom};
            rd = r[DATA_W-1:0];
            rc = CTRL_W'($urandom);
            step(($urandom % 4) != 0, rd, rc, ($urandom % 25) == 0,
                 ($urandom % 3) != 0, ($urandom % 40) == 0);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
